// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the transmit and receive sides.
package i2s_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Wide enough to hold the value DATA_WIDTH itself (saturated slot count).
  function automatic int unsigned bit_cnt_width(input int unsigned data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// 4-entry FIFO with a 2-entry write port and 1-entry read port for stereo pairs.
module i2s_rx_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             free_ge2
);

  logic [WIDTH-1:0] mem_q [4];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       rd_ptr_q;
  logic [2:0]       count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    valid    = (count_q != 3'd0);
    // Space check uses the occupancy before any same-cycle pop.
    free_ge2 = (count_q <= 3'd2);
    do_push  = push && free_ge2;
    do_pop   = pop && valid;
    rdata    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd2;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {do_push, 1'b0} - {2'b00, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q]        <= wdata0;
      mem_q[wr_ptr_q + 2'd1] <= wdata1;
    end
  end

endmodule

// File: rtl/i2s_receive.sv
// Oversampling I2S receiver: deserialises stereo words and emits L/R pairs on AXI4-Stream.
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESET,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  overrun
);

  localparam int unsigned CW = bit_cnt_width(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_s, ws_s, sd_s;
  logic                   sck_prev_q, ws_prev_q, in_sync_q;
  logic [CW-1:0]          bit_cnt_q, cnt_inc, shamt;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_shift, word;
  logic [DATA_WIDTH-1:0]  left_hold_q, push_left_q, push_right_q;
  logic                   left_valid_q, push_q, overrun_q;
  logic                   sck_rise, ws_edge, room;
  logic [DATA_WIDTH:0]    fifo_rdata;
  logic                   fifo_valid, free_ge2;

  always_ff @(posedge M_AXIS_ACLK) begin
    sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
    ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws};
    sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd};
  end

  always_comb begin
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    ws_s        = ws_sync_q[SYNC_STAGES-1];
    sd_s        = sd_sync_q[SYNC_STAGES-1];
    sck_rise    = sck_s && !sck_prev_q;
    ws_edge     = (ws_s != ws_prev_q);
    room        = (bit_cnt_q < CW'(DATA_WIDTH));
    shreg_shift = room ? {shreg_q[DATA_WIDTH-2:0], sd_s} : shreg_q;
    cnt_inc     = room ? bit_cnt_q + CW'(1) : bit_cnt_q;
    // Short slots are left-justified with zero fill.
    shamt       = CW'(DATA_WIDTH) - cnt_inc;
    word        = shreg_shift << shamt;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      sck_prev_q   <= sck_s;
      ws_prev_q    <= ws_s;
      in_sync_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
      push_q       <= 1'b0;
      push_left_q  <= '0;
      push_right_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      push_q     <= 1'b0;
      overrun_q  <= push_q && !free_ge2;
      if (sck_rise) begin
        ws_prev_q <= ws_s;
        if (ws_edge) begin
          bit_cnt_q <= '0;
          shreg_q   <= '0;
          if (!in_sync_q) begin
            in_sync_q <= 1'b1;
          end else if (ws_prev_q == CH_LEFT) begin
            left_hold_q  <= word;
            left_valid_q <= 1'b1;
          end else if (left_valid_q) begin
            push_q       <= 1'b1;
            push_left_q  <= left_hold_q;
            push_right_q <= word;
            left_valid_q <= 1'b0;
          end
        end else begin
          bit_cnt_q <= cnt_inc;
          shreg_q   <= shreg_shift;
        end
      end
    end
  end

  i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (M_AXIS_ACLK),
    .rst      (M_AXIS_ARESET),
    .push     (push_q),
    .wdata0   ({1'b0, push_left_q}),
    .wdata1   ({1'b1, push_right_q}),
    .pop      (M_AXIS_TREADY),
    .rdata    (fifo_rdata),
    .valid    (fifo_valid),
    .free_ge2 (free_ge2)
  );

  always_comb begin
    M_AXIS_TVALID = fifo_valid;
    M_AXIS_TDATA  = fifo_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
    M_AXIS_TLAST  = fifo_valid && fifo_rdata[DATA_WIDTH];
    overrun       = overrun_q;
  end

endmodule

// File: tb/tb_i2s_receive.sv
// Directed bench for i2s_receive: sync, slot lengths, overrun, backpressure, mid-frame reset.
module tb_i2s_receive;
  import i2s_pkg::*;

  logic        M_AXIS_ACLK = 1'b0;
  logic        M_AXIS_ARESET = 1'b1;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b1;
  logic        M_AXIS_TLAST;
  logic        overrun;

  int n_checks = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  logic [32:0] got_q[$];

  i2s_receive #(
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2)
  ) dut (
    .M_AXIS_ACLK   (M_AXIS_ACLK),
    .M_AXIS_ARESET (M_AXIS_ARESET),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .overrun       (overrun)
  );

  always #5 M_AXIS_ACLK = ~M_AXIS_ACLK;

  always @(negedge M_AXIS_ACLK) begin
    if (M_AXIS_TVALID && M_AXIS_TREADY) got_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
    if (overrun) ovr_cnt++;
  end

  // Bits hi..lo of data; ws flips on bit 0 (the LSB slot of this channel).
  task automatic send_bits(input logic ch, input logic [63:0] data, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sck = 1'b0;
      ws  = (i == 0) ? ~ch : ch;
      sd  = data[i];
      #40;
      sck = 1'b1;
      #40;
    end
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    send_bits(CH_LEFT, l, n - 1, 0);
    send_bits(CH_RIGHT, r, n - 1, 0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge M_AXIS_ACLK);
    #1 M_AXIS_TREADY = v;
  endtask

  task automatic wait_beats(input int n, input string name);
    int budget;
    budget = 400;
    while (got_q.size() < n && budget > 0) begin
      @(negedge M_AXIS_ACLK);
      budget--;
    end
    repeat (20) @(negedge M_AXIS_ACLK);
    n_checks++;
    if (got_q.size() != n) begin
      n_fail++;
      $display("FAIL %s beat_count got %0d want %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset;
    M_AXIS_ARESET = 1'b1;
    repeat (5) @(posedge M_AXIS_ACLK);
    #1 M_AXIS_ARESET = 1'b0;
    @(negedge M_AXIS_ACLK);
    n_checks += 4;
    if (M_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", M_AXIS_TVALID); end
    if (M_AXIS_TLAST !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", M_AXIS_TLAST); end
    if (M_AXIS_TDATA !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", M_AXIS_TDATA); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_sync_first_pair;
    got_q.delete();
    send_bits(CH_LEFT, 64'hDEAD_BEEF, 11, 0);
    send_bits(CH_RIGHT, 64'h5555_AAAA, 31, 0);
    send_frame(64'h8000_0001, 64'h7FFF_FFFE, 32);
    wait_beats(2, "sync_pair");
    if (got_q.size() == 2) begin
      n_checks += 2;
      if (got_q[0] !== {1'b0, 32'h8000_0001}) begin n_fail++; $display("FAIL sync_left got %h want 080000001", got_q[0]); end
      if (got_q[1] !== {1'b1, 32'h7FFF_FFFE}) begin n_fail++; $display("FAIL sync_right got %h want 17ffffffe", got_q[1]); end
    end
  endtask

  task automatic test_short_slot;
    got_q.delete();
    send_frame(64'hAB_CDEF, 64'h12_3456, 24);
    wait_beats(2, "short");
    if (got_q.size() == 2) begin
      n_checks += 2;
      if (got_q[0] !== {1'b0, 32'hABCD_EF00}) begin n_fail++; $display("FAIL short_left got %h want 0abcdef00", got_q[0]); end
      if (got_q[1] !== {1'b1, 32'h1234_5600}) begin n_fail++; $display("FAIL short_right got %h want 112345600", got_q[1]); end
    end
  endtask

  task automatic test_long_slot;
    got_q.delete();
    send_frame({24'h0, 32'h1234_5678, 8'hFF}, {24'h0, 32'h9ABC_DEF0, 8'hFF}, 40);
    wait_beats(2, "long");
    if (got_q.size() == 2) begin
      n_checks += 2;
      if (got_q[0] !== {1'b0, 32'h1234_5678}) begin n_fail++; $display("FAIL long_left got %h want 012345678", got_q[0]); end
      if (got_q[1] !== {1'b1, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL long_right got %h want 19abcdef0", got_q[1]); end
    end
  endtask

  task automatic test_overrun;
    logic [32:0] exp [4];
    exp[0] = {1'b0, 32'hA000_000A}; exp[1] = {1'b1, 32'hA000_00A0};
    exp[2] = {1'b0, 32'hB000_000B}; exp[3] = {1'b1, 32'hB000_00B0};
    set_ready(1'b0);
    got_q.delete();
    ovr_cnt = 0;
    send_frame(64'hA000_000A, 64'hA000_00A0, 32);
    send_frame(64'hB000_000B, 64'hB000_00B0, 32);
    n_checks++;
    if (ovr_cnt != 0) begin n_fail++; $display("FAIL ovr_before_c got %0d want 0", ovr_cnt); end
    send_frame(64'hC000_000C, 64'hC000_00C0, 32);
    repeat (20) @(negedge M_AXIS_ACLK);
    n_checks += 3;
    if (ovr_cnt != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt); end
    if (M_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL ovr_tvalid got %b want 1", M_AXIS_TVALID); end
    if ({M_AXIS_TLAST, M_AXIS_TDATA} !== exp[0]) begin
      n_fail++; $display("FAIL ovr_head got %h want %h", {M_AXIS_TLAST, M_AXIS_TDATA}, exp[0]);
    end
    set_ready(1'b1);
    wait_beats(4, "ovr_drain");
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL ovr_beat%0d got %h want %h", i, got_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit done;
    logic pv, pr, pl;
    logic [31:0] pd;
    bit have_prev;
    got_q.delete();
    ovr_cnt = 0;
    done = 0;
    have_prev = 0;
    fork
      begin
        for (int f = 0; f < 8; f++)
          send_frame(64'h1000_0000 + 64'(f), 64'h2000_0000 + 64'(f), 32);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge M_AXIS_ACLK);
          #1 M_AXIS_TREADY = 1'($urandom_range(0, 1));
          @(negedge M_AXIS_ACLK);
          if (have_prev && pv && !pr) begin
            n_checks++;
            if ({M_AXIS_TLAST, M_AXIS_TDATA} !== {pl, pd} || M_AXIS_TVALID !== 1'b1) begin
              n_fail++;
              $display("FAIL bp_stable got %b/%h want %h", M_AXIS_TVALID, {M_AXIS_TLAST, M_AXIS_TDATA},
                       {pl, pd});
            end
          end
          pv = M_AXIS_TVALID; pr = M_AXIS_TREADY; pl = M_AXIS_TLAST; pd = M_AXIS_TDATA;
          have_prev = 1;
        end
      end
    join
    set_ready(1'b1);
    wait_beats(16, "bp_count");
    if (got_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        logic [32:0] e;
        e = (i % 2 == 0) ? {1'b0, 32'h1000_0000 + 32'(i / 2)} : {1'b1, 32'h2000_0000 + 32'(i / 2)};
        n_checks++;
        if (got_q[i] !== e) begin n_fail++; $display("FAIL bp_beat%0d got %h want %h", i, got_q[i], e); end
      end
    end
    n_checks++;
    if (ovr_cnt != 0) begin n_fail++; $display("FAIL bp_overrun got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_mid_frame_reset;
    set_ready(1'b0);
    got_q.delete();
    send_frame(64'hDDDD_0001, 64'hDDDD_0002, 32);
    repeat (10) @(negedge M_AXIS_ACLK);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL mrst_queued got %b want 1", M_AXIS_TVALID); end
    send_bits(CH_LEFT, 64'hEEEE_EEEE, 31, 22);
    @(posedge M_AXIS_ACLK);
    #1 M_AXIS_ARESET = 1'b1;
    @(posedge M_AXIS_ACLK);
    #1 M_AXIS_ARESET = 1'b0;
    @(negedge M_AXIS_ACLK);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL mrst_tvalid got %b want 0", M_AXIS_TVALID); end
    send_bits(CH_LEFT, 64'hEEEE_EEEE, 21, 0);
    send_bits(CH_RIGHT, 64'hFFFF_0000, 31, 0);
    send_frame(64'h0123_4567, 64'h89AB_CDEF, 32);
    set_ready(1'b1);
    wait_beats(2, "mrst_count");
    if (got_q.size() == 2) begin
      n_checks += 2;
      if (got_q[0] !== {1'b0, 32'h0123_4567}) begin n_fail++; $display("FAIL mrst_left got %h want 001234567", got_q[0]); end
      if (got_q[1] !== {1'b1, 32'h89AB_CDEF}) begin n_fail++; $display("FAIL mrst_right got %h want 189abcdef", got_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_sync_first_pair();
    test_short_slot();
    test_long_slot();
    test_overrun();
    test_back_to_back();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
